// File: rtl/gen_reduce_if.sv
// gen_reduce_if: valid/ready input word and output bit channels for gen_reduce_pipe.
// out_count exists only when GEN_REDUCE_COUNT_EN is defined.
interface gen_reduce_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
`ifdef GEN_REDUCE_COUNT_EN
    logic [15:0]      out_count;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_bit, out_count);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_bit, out_count);
`else
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_bit);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_bit);
`endif
endinterface

// File: rtl/gen_reduce_pipe.sv
// gen_reduce_pipe: pipelined CHUNK-ary AND/OR/XOR reduction tree, one register stage per level.
// Defining GEN_REDUCE_COUNT_EN adds a 16-bit wrapping count of delivered results on out_count.
module gen_reduce_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int OP    = 0
) (
    input  logic        clk,
    input  logic        rst,
    gen_reduce_if.slave bus
);
    function automatic int levels_of(input int w, input int c);
        int n = 0;
        while (w > 1) begin
            w = w / c;
            n++;
        end
        return n;
    endfunction
    localparam int LEVELS = levels_of(WIDTH, CHUNK);
    function automatic logic red(input logic [CHUNK-1:0] x);
        return OP == 1 ? |x : OP == 2 ? ^x : &x;
    endfunction
    logic [LEVELS:0] rdy;
    assign rdy[LEVELS] = bus.out_ready;
    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        localparam int N = WIDTH / CHUNK**(k+1);
        logic [N*CHUNK-1:0] src;
        logic               src_v;
        logic [N-1:0]       nxt;
        logic [N-1:0]       q;
        logic               v;
        if (k == 0) begin : g_src
            assign src   = bus.in_data;
            assign src_v = bus.in_valid;
        end else begin : g_src
            assign src   = lvl[k-1].q;
            assign src_v = lvl[k-1].v;
        end
        for (genvar i = 0; i < N; i++) begin : node
            assign nxt[i] = red(src[i*CHUNK +: CHUNK]);
        end
        // An empty stage accepts even while everything downstream stalls, so bubbles collapse.
        assign rdy[k] = !v | rdy[k+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= 1'b0;
                q <= '0;
            end else if (rdy[k]) begin
                v <= src_v;
                if (src_v) q <= nxt;
            end
        end
    end
    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = lvl[LEVELS-1].v;
    assign bus.out_bit   = lvl[LEVELS-1].q[0];
`ifdef GEN_REDUCE_COUNT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (lvl[LEVELS-1].v && bus.out_ready) cnt <= cnt + 16'd1;
    end
    assign bus.out_count = cnt;
`endif
endmodule

// File: tb/tb_gen_reduce_pipe.sv
// tb_gen_reduce_pipe: AND and XOR instances driven in lockstep, checked against a scoreboard queue.
module tb_gen_reduce_pipe;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1;
    logic        bulk = 0;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  sb[$];

    typedef struct {
        logic [15:0] d;
        logic        ea;
        logic        ex;
    } vec_t;
    vec_t tbl[10];

    gen_reduce_if #(.WIDTH(16)) ia ();
    gen_reduce_if #(.WIDTH(16)) ix ();
    assign ia.in_valid  = in_valid;
    assign ia.in_data   = in_data;
    assign ia.out_ready = out_ready;
    assign ix.in_valid  = in_valid;
    assign ix.in_data   = in_data;
    assign ix.out_ready = out_ready;

    gen_reduce_pipe #(.WIDTH(16), .CHUNK(4), .OP(0)) u_and (.clk(clk), .rst(rst), .bus(ia.slave));
    gen_reduce_pipe #(.WIDTH(16), .CHUNK(4), .OP(2)) u_xor (.clk(clk), .rst(rst), .bus(ix.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !bulk) begin
            chk("valid_match", 32'(ix.out_valid), 32'(ia.out_valid));
            if (ia.out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got output bit %0b expected no output", ia.out_bit);
                end else begin
                    logic [1:0] e;
                    e = sb.pop_front();
                    chk("and_bit", 32'(ia.out_bit), 32'(e[1]));
                    chk("xor_bit", 32'(ix.out_bit), 32'(e[0]));
                end
            end
        end
    end

    // Starts and ends at posedge+1; the expectation is queued at the accepting edge.
    task automatic send(input logic [15:0] d, input logic ea, input logic ex);
        in_valid = 1;
        in_data  = d;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (ia.in_ready) begin
                sb.push_back({ea, ex});
                break;
            end
            if (t > 60) begin
                chk("send_timeout", 32'(ia.in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (sb.size() != 0 || ia.out_valid); t++) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{16'h0001, 1'b0, 1'b1};
        tbl[1] = '{16'h0003, 1'b0, 1'b0};
        tbl[2] = '{16'h8421, 1'b0, 1'b0};
        tbl[3] = '{16'hFFFF, 1'b1, 1'b0};
        tbl[4] = '{16'h7FFF, 1'b0, 1'b1};
        tbl[5] = '{16'h0000, 1'b0, 1'b0};
        tbl[6] = '{16'hAAAA, 1'b0, 1'b0};
        tbl[7] = '{16'h1000, 1'b0, 1'b1};
        tbl[8] = '{16'hFFFE, 1'b0, 1'b1};
        tbl[9] = '{16'hFFFF, 1'b1, 1'b0};

        #1 rst = 1;
        #1;
        chk("rst_and_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_xor_valid", 32'(ix.out_valid), 32'd0);
        chk("rst_out_bit", 32'(ia.out_bit), 32'd0);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        send(16'hFFFF, 1'b1, 1'b0);
        chk("lat_not_yet", 32'(ia.out_valid), 32'd0);
        send(16'hFFFE, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_v1", 32'(ia.out_valid), 32'd1);
        chk("lat_b1", 32'(ia.out_bit), 32'd1);
        @(negedge clk);
        chk("lat_v2", 32'(ia.out_valid), 32'd1);
        chk("lat_b2", 32'(ia.out_bit), 32'd0);
        drain();

        for (int n = 0; n < 10; n++) send(tbl[n].d, tbl[n].ea, tbl[n].ex);
        drain();

        out_ready = 0;
        fork
            begin
                send(16'hFFFF, 1'b1, 1'b0);
                send(16'h0001, 1'b0, 1'b1);
                send(16'hF0F0, 1'b0, 1'b0);
            end
        join_none
        repeat (5) @(negedge clk);
        chk("bp_in_ready", 32'(ia.in_ready), 32'd0);
        chk("bp_out_valid", 32'(ia.out_valid), 32'd1);
        chk("bp_held_bit", 32'(ia.out_bit), 32'd1);
        chk("bp_queued", 32'(sb.size()), 32'd2);
        @(posedge clk);
        #1 out_ready = 1;
        wait fork;
        drain();

        out_ready = 0;
        send(16'h0FFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("bub_ready_a", 32'(ia.in_ready), 32'd1);
        @(negedge clk);
        chk("bub_out_valid", 32'(ia.out_valid), 32'd1);
        chk("bub_ready_b", 32'(ia.in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(16'h00FF, 1'b0, 1'b0);
        @(negedge clk);
        chk("bub_full", 32'(ia.in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1;
        drain();

        out_ready = 0;
        send(16'hFFFF, 1'b1, 1'b0);
        send(16'hFFFF, 1'b1, 1'b0);
        #3 rst = 1;
        sb.delete();
        #1;
        chk("mrst_valid", 32'(ia.out_valid), 32'd0);
        chk("mrst_bit", 32'(ia.out_bit), 32'd0);
        chk("mrst_ready", 32'(ia.in_ready), 32'd1);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1 out_ready = 1;
        repeat (4) @(negedge clk);
        chk("mrst_no_stale", 32'(ia.out_valid), 32'd0);
        @(posedge clk);
        #1;

        begin
            bit done;
            done = 0;
            fork
                begin
                    logic [15:0] d;
                    for (int n = 0; n < 40; n++) begin
                        d = 16'($urandom);
                        send(d, &d, ^d);
                    end
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1 out_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            out_ready = 1;
            drain();
        end

`ifdef GEN_REDUCE_COUNT_EN
        rst = 1;
        #1;
        chk("cnt_rst", 32'(ia.out_count), 32'd0);
        @(negedge clk);
        rst = 0;
        bulk = 1;
        @(posedge clk);
        #1;
        in_data  = 16'hFFFF;
        in_valid = 1;
        repeat (65537) @(posedge clk);
        #1 in_valid = 0;
        repeat (4) @(negedge clk);
        chk("cnt_wrap_and", 32'(ia.out_count), 32'd1);
        chk("cnt_wrap_xor", 32'(ix.out_count), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
